stdp_update_scheduler: RTL and testbench
========================================

STDP_UPDATE_SCHEDULER -- requirements
Module: stdp_update_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PRE, default 4, meaning the number of presynaptic lanes; only 4 is supported.
REQ-002 The block SHALL have parameter WINDOW, default 14, meaning the STDP window in cycles; legal range 0..14.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pre_spike  input  4  per-lane presynaptic spike, one-cycle pulses.
REQ-006 post_spike  input  1  postsynaptic spike, one-cycle pulse.
REQ-007 upd_valid  output  1  update request to the shared weight-update unit.
REQ-008 upd_ready  input  1  weight-update unit accepts; a handshake occurs when upd_valid and upd_ready are both high in the same cycle.
REQ-009 upd_idx  output  2  lane being updated.
REQ-010 upd_ltp  output  1  1 = potentiate, 0 = depress.
REQ-011 upd_dt  output  4  spike time difference magnitude, 0..15.
REQ-012 pending  output  4  per-lane request-slot occupancy.
REQ-013 overflow  output  1  sticky flag: a request was dropped.

Function
REQ-014 Each lane SHALL keep an 8-bit pre_age register: it loads 0 in the cycle after pre_spike[i], otherwise increments and saturates at 255.
REQ-015 A single 8-bit post_age register SHALL follow the same rule using post_spike.
REQ-016 LTP event: if post_spike=1 in cycle t and the lane's pre_age ≤ WINDOW at t, lane i SHALL raise a request with ltp=1 and dt=pre_age+1.
REQ-017 Coincidence: if post_spike=1 and pre_spike[i]=1 in the same cycle, lane i SHALL raise ltp=1, dt=0; REQ-018 SHALL NOT also fire for that lane.
REQ-018 LTD event: if pre_spike[i]=1 and post_spike=0 in cycle t and post_age ≤ WINDOW at t, lane i SHALL raise a request with ltp=0 and dt=post_age+1.
REQ-019 Ages above WINDOW, including the saturated value 255, SHALL NOT generate requests.
REQ-020 Each lane SHALL have a one-entry slot {valid, ltp, dt}; a request raised in cycle t SHALL set the slot, visible on pending at t+1.
REQ-021 A request to an occupied slot SHALL be dropped, the slot SHALL stay unchanged, and overflow SHALL be set at t+1 and held until reset.
REQ-022 Exception to REQ-021: if the occupied slot is handshaken in the same cycle t, the new request SHALL be loaded and SHALL NOT be dropped.
REQ-023 The scheduler FSM SHALL have two states, IDLE and ISSUE; reset enters IDLE.
REQ-024 IDLE with any pending bit set: select a lane, register upd_idx/upd_ltp/upd_dt from its slot, assert upd_valid next cycle, and go to ISSUE; the event-to-upd_valid minimum latency is 2 cycles.
REQ-025 Selection SHALL be round-robin: search starts at the lane after the last granted lane; after reset the search starts at lane 0.
REQ-026 In ISSUE with upd_ready=0, upd_valid, upd_idx, upd_ltp and upd_dt SHALL hold stable.
REQ-027 In ISSUE on handshake, the granted slot SHALL clear and the pointer SHALL advance past it.
REQ-028 After the handshake of REQ-027, if any other slot is pending, the next lane SHALL be presented the following cycle (back-to-back) and the FSM stays in ISSUE; otherwise upd_valid drops and the FSM returns to IDLE.
REQ-029 A slot being offered SHALL remain set in pending until its handshake; upd_valid SHALL never be high when pending is zero.
REQ-030 Granted-lane slot contents SHALL be copied at selection; later events on other lanes SHALL NOT alter the offered outputs.

Reset
REQ-031 When rst=1 at a clock edge, the next cycle SHALL have: upd_valid=0, upd_idx=0, upd_ltp=0, upd_dt=0, pending=0, overflow=0, all ages=255, FSM=IDLE, round-robin pointer at lane 0.
REQ-032 Reset mid-handshake SHALL abandon the offered update without completing it, and no request SHALL issue from pre-reset events.
REQ-033 Spikes in the cycle rst=1 SHALL be ignored.

Verification
REQ-034 Scenario: pre_spike=0001 at t0, post_spike at t0+3, upd_ready=1 -> upd_valid at t0+5 with idx=0, ltp=1, dt=3, pending returns to 0 at t0+6.
REQ-035 Scenario: post_spike at t0, pre_spike=0100 at t0+5 -> idx=2, ltp=0, dt=5; with WINDOW=14, a pre spike at t0+20 -> no request.
REQ-036 Scenario: pre_spike=1111 at t0, post_spike at t0+1, upd_ready held 0 for 4 cycles then 1 -> outputs are stable while stalled, then grants occur in order 0,1,2,3 on consecutive cycles, all with dt=1.
REQ-037 Scenario: pre_spike=0001 and post_spike in the same cycle -> ltp=1, dt=0, and no LTD request.
REQ-038 Scenario: lane 1 pending with upd_ready=0 and a second lane-1 event arrives -> overflow=1 sticky, and the original dt is delivered; repeat with the handshake in the event cycle -> no overflow.
REQ-039 Scenario: rst asserted while upd_valid=1 -> all outputs are at REQ-031 values the next cycle, and no further upd_valid occurs without new spikes.

Source files
------------

// File: rtl/stdp_update_scheduler.sv
// STDP update scheduler: per-lane pre/post spike ages feed one-entry request slots,
// which a round-robin issuer drains to a shared weight-update unit over valid/ready.
module stdp_update_scheduler #(
    parameter int unsigned NUM_PRE = 4,
    parameter int unsigned WINDOW  = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PRE-1:0]         pre_spike,
    input  logic                       post_spike,
    output logic                       upd_valid,
    input  logic                       upd_ready,
    output logic [$clog2(NUM_PRE)-1:0] upd_idx,
    output logic                       upd_ltp,
    output logic [3:0]                 upd_dt,
    output logic [NUM_PRE-1:0]         pending,
    output logic                       overflow
);

    localparam int unsigned AGE_W = 8;
    localparam int unsigned DT_W  = 4;
    localparam int unsigned IDX_W = $clog2(NUM_PRE);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] WIN     = AGE_W'(WINDOW);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state, state_d;
    logic [AGE_W-1:0]       pre_age [NUM_PRE];
    logic [AGE_W-1:0]       post_age;
    logic [NUM_PRE-1:0]     slot_ltp;
    logic [DT_W-1:0]        slot_dt [NUM_PRE];
    logic [NUM_PRE-1:0]     req, req_ltp, grant_hs, slot_free;
    logic [DT_W-1:0]        req_dt [NUM_PRE];
    logic [IDX_W-1:0]       ptr, ptr_d, idx_d;
    logic                   valid_d, ltp_d;
    logic [DT_W-1:0]        dt_d;
    logic [IDX_W:0]         pick_idle, pick_next;

    function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
        return (a == AGE_MAX) ? a : a + AGE_W'(1);
    endfunction

    // First set lane of mask at or after start, wrapping; returns {found, lane}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PRE-1:0] mask,
                                               input logic [IDX_W-1:0]   start);
        logic             found;
        logic [IDX_W-1:0] lane, sel;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_PRE; k++) begin
            lane = start + IDX_W'(k);
            if (!found && mask[lane]) begin
                found = 1'b1;
                sel   = lane;
            end
        end
        return {found, sel};
    endfunction

    // Event detection; coincidence wins over LTP, LTD needs no post spike this cycle.
    always_comb begin
        req     = '0;
        req_ltp = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            req_dt[i]    = '0;
            grant_hs[i]  = upd_valid && upd_ready && (upd_idx == IDX_W'(i));
            slot_free[i] = !pending[i] || grant_hs[i];
            if (post_spike && pre_spike[i]) begin
                req[i]     = 1'b1;
                req_ltp[i] = 1'b1;
            end else if (post_spike && (pre_age[i] <= WIN)) begin
                req[i]     = 1'b1;
                req_ltp[i] = 1'b1;
                req_dt[i]  = DT_W'(pre_age[i] + AGE_W'(1));
            end else if (pre_spike[i] && !post_spike && (post_age <= WIN)) begin
                req[i]     = 1'b1;
                req_dt[i]  = DT_W'(post_age + AGE_W'(1));
            end
        end
    end

    // Ages and request slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            post_age <= AGE_MAX;
            overflow <= 1'b0;
            pending  <= '0;
            slot_ltp <= '0;
            for (int i = 0; i < NUM_PRE; i++) begin
                pre_age[i] <= AGE_MAX;
                slot_dt[i] <= '0;
            end
        end else begin
            post_age <= post_spike ? '0 : sat_inc(post_age);
            for (int i = 0; i < NUM_PRE; i++) begin
                pre_age[i] <= pre_spike[i] ? '0 : sat_inc(pre_age[i]);
                if (req[i]) begin
                    if (slot_free[i]) begin
                        pending[i]  <= 1'b1;
                        slot_ltp[i] <= req_ltp[i];
                        slot_dt[i]  <= req_dt[i];
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (grant_hs[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Next lane after a handshake excludes the lane being retired.
    assign pick_idle = rr_pick(pending, ptr);
    assign pick_next = rr_pick(pending & ~(NUM_PRE'(1) << upd_idx), upd_idx + IDX_W'(1));

    always_comb begin
        state_d = state;
        valid_d = upd_valid;
        idx_d   = upd_idx;
        ltp_d   = upd_ltp;
        dt_d    = upd_dt;
        ptr_d   = ptr;
        case (state)
            IDLE: begin
                if (pick_idle[IDX_W]) begin
                    valid_d = 1'b1;
                    idx_d   = pick_idle[IDX_W-1:0];
                    ltp_d   = slot_ltp[pick_idle[IDX_W-1:0]];
                    dt_d    = slot_dt[pick_idle[IDX_W-1:0]];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (upd_ready) begin
                    ptr_d = upd_idx + IDX_W'(1);
                    if (pick_next[IDX_W]) begin
                        idx_d = pick_next[IDX_W-1:0];
                        ltp_d = slot_ltp[pick_next[IDX_W-1:0]];
                        dt_d  = slot_dt[pick_next[IDX_W-1:0]];
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            upd_valid <= 1'b0;
            upd_idx   <= '0;
            upd_ltp   <= 1'b0;
            upd_dt    <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_d;
            upd_valid <= valid_d;
            upd_idx   <= idx_d;
            upd_ltp   <= ltp_d;
            upd_dt    <= dt_d;
            ptr       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Bench for stdp_update_scheduler: directed scenarios with fixed expectations plus
// randomized traffic compared each cycle against a behavioural model.
module tb_stdp_update_scheduler;

    localparam int WINDOW = 14;

    logic       clk = 1'b0;
    logic       rst, post_spike, upd_ready;
    logic [3:0] pre_spike;
    logic       upd_valid, upd_ltp, overflow;
    logic [1:0] upd_idx;
    logic [3:0] upd_dt, pending;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state (value seen during the current cycle).
    int m_pre_age[4];
    int m_post_age;
    bit m_pend[4];
    bit m_ltp[4];
    int m_dt[4];
    bit m_ovf, m_valid, m_oltp;
    int m_idx, m_odt, m_ptr;

    stdp_update_scheduler #(.NUM_PRE(4), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst(rst), .pre_spike(pre_spike), .post_spike(post_spike),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
        .upd_ltp(upd_ltp), .upd_dt(upd_dt), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [3:0] pre, input logic post,
                              input logic rdy, input logic r);
        bit req[4];
        bit rl[4];
        int rd[4];
        bit old_pend[4];
        bit old_ltp[4];
        int old_dt[4];
        bit hs;
        int pick, lane;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_pre_age[i] = 255; m_pend[i] = 0; m_ltp[i] = 0; m_dt[i] = 0;
            end
            m_post_age = 255; m_ovf = 0; m_valid = 0; m_oltp = 0;
            m_idx = 0; m_odt = 0; m_ptr = 0;
            return;
        end
        hs = m_valid && rdy;
        old_pend = m_pend; old_ltp = m_ltp; old_dt = m_dt;
        for (int i = 0; i < 4; i++) begin
            req[i] = 0; rl[i] = 0; rd[i] = 0;
            if (post && pre[i]) begin
                req[i] = 1; rl[i] = 1; rd[i] = 0;
            end else if (post && m_pre_age[i] <= WINDOW) begin
                req[i] = 1; rl[i] = 1; rd[i] = m_pre_age[i] + 1;
            end else if (pre[i] && !post && m_post_age <= WINDOW) begin
                req[i] = 1; rl[i] = 0; rd[i] = m_post_age + 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (m_pend[i] && !(hs && m_idx == i)) m_ovf = 1;
                else begin m_pend[i] = 1; m_ltp[i] = rl[i]; m_dt[i] = rd[i]; end
            end else if (hs && m_idx == i) begin
                m_pend[i] = 0;
            end
            m_pre_age[i] = pre[i] ? 0 : ((m_pre_age[i] < 255) ? m_pre_age[i] + 1 : 255);
        end
        m_post_age = post ? 0 : ((m_post_age < 255) ? m_post_age + 1 : 255);
        if (!m_valid || hs) begin
            pick = -1;
            if (hs) m_ptr = (m_idx + 1) % 4;
            for (int k = 0; k < 4; k++) begin
                lane = (m_ptr + k) % 4;
                if (pick < 0 && old_pend[lane] && !(hs && lane == m_idx)) pick = lane;
            end
            if (pick >= 0) begin
                m_valid = 1; m_idx = pick; m_oltp = old_ltp[pick]; m_odt = old_dt[pick];
            end else begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: model consumes this cycle's inputs, then sample 1 ns after the edge.
    task automatic tick();
        model_step(pre_spike, post_spike, upd_ready, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; pre_spike = 0; post_spike = 0; upd_ready = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; pre_spike = 4'b1111; post_spike = 1; upd_ready = 1;
        tick();
        rst = 0; pre_spike = 0; post_spike = 0;
        n_vec++;
        if ({upd_valid, upd_idx, upd_ltp, upd_dt, pending, overflow} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b want 0", {upd_valid, upd_idx, upd_ltp, upd_dt, pending, overflow});
        end
        post_spike = 1;
        tick();
        post_spike = 0;
        n_vec++;
        if (pending !== 4'b0000) begin
            n_err++; $display("FAIL reset_spikes_ignored: pending got %b want 0000", pending);
        end
    endtask

    task automatic test_ltp();
        do_reset();
        pre_spike = 4'b0001; tick(); pre_spike = 0;
        tick(); tick();
        post_spike = 1; tick(); post_spike = 0;
        upd_ready = 1;
        n_vec++;
        if ({upd_valid, pending} !== {1'b0, 4'b0001}) begin
            n_err++; $display("FAIL ltp_pending: got %b want 00001", {upd_valid, pending});
        end
        tick();
        n_vec++;
        if ({upd_valid, upd_idx, upd_ltp, upd_dt} !== {1'b1, 2'd0, 1'b1, 4'd3}) begin
            n_err++; $display("FAIL ltp_offer: got %b want 1_00_1_0011", {upd_valid, upd_idx, upd_ltp, upd_dt});
        end
        tick();
        n_vec++;
        if ({upd_valid, pending} !== 5'b0) begin
            n_err++; $display("FAIL ltp_retire: got %b want 00000", {upd_valid, pending});
        end
    endtask

    task automatic test_ltd_window();
        do_reset();
        upd_ready = 1;
        post_spike = 1; tick(); post_spike = 0;
        repeat (4) tick();
        pre_spike = 4'b0100; tick(); pre_spike = 0;
        tick();
        n_vec++;
        if ({upd_valid, upd_idx, upd_ltp, upd_dt} !== {1'b1, 2'd2, 1'b0, 4'd5}) begin
            n_err++; $display("FAIL ltd_offer: got %b want 1_10_0_0101", {upd_valid, upd_idx, upd_ltp, upd_dt});
        end
        repeat (12) tick();
        pre_spike = 4'b0100; tick(); pre_spike = 0;
        tick();
        n_vec++;
        if ({upd_valid, pending, overflow} !== 6'b0) begin
            n_err++; $display("FAIL ltd_outside_window: got %b want 000000", {upd_valid, pending, overflow});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pre_spike = 4'b1111; tick(); pre_spike = 0;
        post_spike = 1; tick(); post_spike = 0;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if ({upd_valid, upd_idx, upd_ltp, upd_dt} !== {1'b1, 2'd0, 1'b1, 4'd1}) begin
                n_err++; $display("FAIL stall_hold cycle %0d: got %b want 1_00_1_0001", c, {upd_valid, upd_idx, upd_ltp, upd_dt});
            end
            tick();
        end
        upd_ready = 1;
        for (int lane = 0; lane < 4; lane++) begin
            n_vec++;
            if ({upd_valid, upd_idx, upd_ltp, upd_dt} !== {1'b1, 2'(lane), 1'b1, 4'd1}) begin
                n_err++; $display("FAIL rr_grant lane %0d: got %b want valid/idx/ltp/dt 1_%b_1_0001", lane, {upd_valid, upd_idx, upd_ltp, upd_dt}, 2'(lane));
            end
            tick();
        end
        n_vec++;
        if ({upd_valid, pending, overflow} !== 6'b0) begin
            n_err++; $display("FAIL rr_drain: got %b want 000000", {upd_valid, pending, overflow});
        end
    endtask

    task automatic test_coincidence();
        do_reset();
        pre_spike = 4'b0001; post_spike = 1; tick(); pre_spike = 0; post_spike = 0;
        upd_ready = 1;
        tick();
        n_vec++;
        if ({upd_valid, upd_idx, upd_ltp, upd_dt} !== {1'b1, 2'd0, 1'b1, 4'd0}) begin
            n_err++; $display("FAIL coincidence_offer: got %b want 1_00_1_0000", {upd_valid, upd_idx, upd_ltp, upd_dt});
        end
        repeat (3) tick();
        n_vec++;
        if ({upd_valid, pending, overflow} !== 6'b0) begin
            n_err++; $display("FAIL coincidence_no_ltd: got %b want 000000", {upd_valid, pending, overflow});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        post_spike = 1; tick(); post_spike = 0;
        pre_spike = 4'b0010; tick(); pre_spike = 0;
        tick();
        pre_spike = 4'b0010; tick(); pre_spike = 0;
        n_vec++;
        if ({overflow, pending} !== {1'b1, 4'b0010}) begin
            n_err++; $display("FAIL overflow_set: got %b want 10010", {overflow, pending});
        end
        tick(); tick();
        n_vec++;
        if ({upd_valid, upd_idx, upd_dt, overflow} !== {1'b1, 2'd1, 4'd1, 1'b1}) begin
            n_err++; $display("FAIL overflow_orig_dt: got %b want 1_01_0001_1", {upd_valid, upd_idx, upd_dt, overflow});
        end
        upd_ready = 1; tick();
        n_vec++;
        if ({upd_valid, pending, overflow} !== {1'b0, 4'b0000, 1'b1}) begin
            n_err++; $display("FAIL overflow_sticky: got %b want 000001", {upd_valid, pending, overflow});
        end
        do_reset();
        post_spike = 1; tick(); post_spike = 0;
        pre_spike = 4'b0010; tick(); pre_spike = 0;
        tick();
        upd_ready = 1; pre_spike = 4'b0010; tick(); pre_spike = 0;
        n_vec++;
        if ({overflow, pending, upd_valid} !== {1'b0, 4'b0010, 1'b0}) begin
            n_err++; $display("FAIL hs_reload: got %b want 000100", {overflow, pending, upd_valid});
        end
        tick();
        n_vec++;
        if ({upd_valid, upd_idx, upd_ltp, upd_dt} !== {1'b1, 2'd1, 1'b0, 4'd3}) begin
            n_err++; $display("FAIL hs_reload_offer: got %b want 1_01_0_0011", {upd_valid, upd_idx, upd_ltp, upd_dt});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pre_spike = 4'b1010; tick(); pre_spike = 0;
        post_spike = 1; tick(); post_spike = 0;
        tick();
        n_vec++;
        if (upd_valid !== 1'b1) begin
            n_err++; $display("FAIL midreset_precond: upd_valid got %b want 1", upd_valid);
        end
        upd_ready = 1; rst = 1; tick(); rst = 0;
        n_vec++;
        if ({upd_valid, upd_idx, upd_ltp, upd_dt, pending, overflow} !== 13'd0) begin
            n_err++; $display("FAIL midreset_state: got %b want 0", {upd_valid, upd_idx, upd_ltp, upd_dt, pending, overflow});
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_vec++;
            if ({upd_valid, pending} !== 5'b0) begin
                n_err++; $display("FAIL midreset_quiet cycle %0d: got %b want 00000", c, {upd_valid, pending});
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_p;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) pre_spike[i] = ($urandom_range(0, 5) == 0);
            post_spike = ($urandom_range(0, 7) == 0);
            upd_ready  = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 399) == 0);
            tick();
            for (int i = 0; i < 4; i++) exp_p[i] = m_pend[i];
            n_vec++;
            if ({upd_valid, pending, overflow} !== {m_valid, exp_p, m_ovf}) begin
                n_err++;
                $display("FAIL rand_status cycle %0d: valid/pending/ovf got %b want %b", c, {upd_valid, pending, overflow}, {m_valid, exp_p, m_ovf});
            end
            if (m_valid) begin
                n_vec++;
                if ({upd_idx, upd_ltp, upd_dt} !== {2'(m_idx), m_oltp, 4'(m_odt)}) begin
                    n_err++;
                    $display("FAIL rand_offer cycle %0d: idx/ltp/dt got %b want %b", c, {upd_idx, upd_ltp, upd_dt}, {2'(m_idx), m_oltp, 4'(m_odt)});
                end
            end
        end
        rst = 0; pre_spike = 0; post_spike = 0;
    endtask

    initial begin
        rst = 1; pre_spike = 0; post_spike = 0; upd_ready = 0;
        test_reset();
        test_ltp();
        test_ltd_window();
        test_back_to_back();
        test_coincidence();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
